// File: rtl/skewed_desync.sv
// Skewed desynchronizer: pushes the SCC of a pair of unary bitstreams toward -1.
// 1s of in0 that coincide with 1s of in1 are held back and re-emitted in cycles
// where both inputs are 0. The last 2^DEP cycles of each window drain the store
// unconditionally; anything left at the window end is reported on drop/drop_vld.
module skewed_desync #(
   parameter int unsigned DEP   = 2,
   parameter int unsigned LEN_W = 8   // must exceed DEP
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           en,
   input  logic           in0,
   input  logic           in1,
   output logic           out0,
   output logic           out1,
   output logic [DEP-1:0] cnt_o,
   output logic           drain_o,
   output logic [DEP-1:0] drop,
   output logic           drop_vld
);

   localparam logic [DEP-1:0]   Full       = '1;
   localparam logic [LEN_W-1:0] PosLast    = '1;
   // First DRAIN position: 2^LEN_W - 2^DEP, i.e. upper bits all ones, low DEP bits zero.
   localparam logic [LEN_W-1:0] DrainStart = {{(LEN_W - DEP){1'b1}}, {DEP{1'b0}}};

   logic [DEP-1:0]   cnt_q, cnt_d;
   logic [LEN_W-1:0] pos_q;
   logic [DEP-1:0]   drop_q;
   logic             drop_vld_q;
   logic             active;

   assign active   = rst_n & en;
   assign drain_o  = (pos_q >= DrainStart);
   assign out1     = in1;
   assign cnt_o    = cnt_q;
   assign drop     = drop_q;
   assign drop_vld = drop_vld_q;

   // Output bit and next occupancy: absorb/release in ACCUM, release only in DRAIN.
   always_comb begin
      out0  = in0;
      cnt_d = cnt_q;
      if (active) begin
         if (!drain_o) begin
            if (in0 && in1) begin
               if (cnt_q != Full) begin
                  out0  = 1'b0;
                  cnt_d = cnt_q + 1'b1;
               end
            end else if (!in0 && !in1) begin
               if (cnt_q != '0) begin
                  out0  = 1'b1;
                  cnt_d = cnt_q - 1'b1;
               end
            end
         end else if (!in0 && (cnt_q != '0)) begin
            out0  = 1'b1;
            cnt_d = cnt_q - 1'b1;
         end
      end
   end

   // Window position, occupancy and end-of-window residual report.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q      <= '0;
         pos_q      <= '0;
         drop_q     <= '0;
         drop_vld_q <= 1'b0;
      end else if (en) begin
         pos_q <= pos_q + 1'b1;
         if (pos_q == PosLast) begin
            cnt_q      <= '0;
            drop_q     <= cnt_d;
            drop_vld_q <= (cnt_d != '0);
         end else begin
            cnt_q      <= cnt_d;
            drop_vld_q <= 1'b0;
         end
      end else begin
         drop_vld_q <= 1'b0;
      end
   end

endmodule

// File: tb/tb_skewed_desync.sv
// Directed bench for skewed_desync with DEP=2, LEN_W=4 (16-cycle window, DRAIN at 12..15).
module tb_skewed_desync;

   logic       clk = 1'b0;
   logic       rst_n, en, in0, in1;
   logic       out0, out1, drain_o, drop_vld;
   logic [1:0] cnt_o, drop;

   int total = 0;
   int bad   = 0;

   skewed_desync #(.DEP(2), .LEN_W(4)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en),
      .in0      (in0),
      .in1      (in1),
      .out0     (out0),
      .out1     (out1),
      .cnt_o    (cnt_o),
      .drain_o  (drain_o),
      .drop     (drop),
      .drop_vld (drop_vld)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s got=%0d want=%0d at %0t", tag, obs, exp, $time);
      end
   endtask

   // Apply one cycle: check combinational outputs, clock, then check registered outputs.
   task automatic cyc(input logic e, input logic a, input logic b,
                      input logic x_out0, input logic x_drain,
                      input int x_cnt, input logic x_vld);
      en = e; in0 = a; in1 = b;
      #1;
      check("out0", out0, x_out0);
      check("drain_o", drain_o, x_drain);
      check("out1", out1, b);
      @(posedge clk);
      #1;
      check("cnt_o", cnt_o, x_cnt);
      check("drop_vld", drop_vld, x_vld);
   endtask

   initial begin
      logic ra, rb;
      rst_n = 1'b0; en = 1'b0; in0 = 1'b0; in1 = 1'b0;
      @(posedge clk);
      #1;
      // Reset: passthrough while held, all state cleared.
      cyc(1, 1, 1, 1, 0, 0, 0);
      cyc(1, 0, 1, 0, 0, 0, 0);
      check("rst_drop", drop, 0);
      rst_n = 1'b1;

      // Window 1. Saturate at pos 0..3.
      cyc(1, 1, 1, 0, 0, 1, 0);
      cyc(1, 1, 1, 0, 0, 2, 0);
      cyc(1, 1, 1, 0, 0, 3, 0);
      cyc(1, 1, 1, 1, 0, 3, 0);
      // Release at pos 4..7.
      cyc(1, 0, 0, 1, 0, 2, 0);
      cyc(1, 0, 0, 1, 0, 1, 0);
      cyc(1, 0, 0, 1, 0, 0, 0);
      cyc(1, 0, 0, 0, 0, 0, 0);
      // Refill to 2 at pos 8..9, passthrough at 10..11.
      cyc(1, 1, 1, 0, 0, 1, 0);
      cyc(1, 1, 1, 0, 0, 2, 0);
      cyc(1, 1, 0, 1, 0, 2, 0);
      cyc(1, 0, 1, 0, 0, 2, 0);
      // Drain at pos 12..15: store empties regardless of in1, nothing dropped.
      cyc(1, 0, 1, 1, 1, 1, 0);
      cyc(1, 0, 1, 1, 1, 0, 0);
      cyc(1, 1, 1, 1, 1, 0, 0);
      cyc(1, 1, 1, 1, 1, 0, 0);
      check("w1_drop", drop, 0);

      // Window 2. Fill to 2, then 4 passthrough cycles.
      cyc(1, 1, 1, 0, 0, 1, 0);
      cyc(1, 1, 1, 0, 0, 2, 0);
      cyc(1, 1, 0, 1, 0, 2, 0);
      cyc(1, 0, 1, 0, 0, 2, 0);
      cyc(1, 1, 0, 1, 0, 2, 0);
      cyc(1, 0, 1, 0, 0, 2, 0);
      // Fill to 3 at pos 6, hold through pos 11.
      cyc(1, 1, 1, 0, 0, 3, 0);
      for (int i = 7; i < 12; i++) cyc(1, 1, 0, 1, 0, 3, 0);
      // DRAIN with in0=1: no release possible, 3 left at window end.
      for (int i = 12; i < 15; i++) cyc(1, 1, 1, 1, 1, 3, 0);
      cyc(1, 1, 1, 1, 1, 0, 1);
      check("w2_drop", drop, 3);

      // Window 3: drop_vld is a single pulse, drop holds.
      cyc(1, 1, 0, 1, 0, 0, 0);
      check("w3_drop_hold", drop, 3);
      cyc(1, 1, 1, 0, 0, 1, 0);
      cyc(1, 1, 1, 0, 0, 2, 0);
      // Stall at pos 3: random inputs pass through, state frozen.
      for (int i = 0; i < 5; i++) begin
         ra = 1'($urandom_range(0, 1));
         rb = 1'($urandom_range(0, 1));
         cyc(0, ra, rb, ra, 0, 2, 0);
      end
      check("stall_drop", drop, 3);
      // pos 3..11 still ACCUM, confirming pos did not move during the stall.
      for (int i = 3; i < 12; i++) cyc(1, 1, 0, 1, 0, 2, 0);
      // Reset at pos 12 with cnt=2: silently abandoned, passthrough during reset.
      rst_n = 1'b0;
      cyc(1, 1, 1, 1, 1, 0, 0);
      check("rst2_drop", drop, 0);
      rst_n = 1'b1;
      // New window from pos 0: 12 ACCUM cycles then DRAIN.
      for (int i = 0; i < 12; i++) cyc(1, 0, 0, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 1, 0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

endmodule
